conv_job_sequencer: RTL and testbench
=====================================

CONV_JOB_SEQUENCER -- requirements
Module: conv_job_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, default 256, pixels per image job (range 1..65535).
REQ-002 Parameter KERNEL_WAIT, default 16, cycles read_kernel is held before the kernel is treated as loaded (range 1..255).
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles after the last pixel before done, covering write-path latency (range 0..15).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  job request level from PS GPIO; the rising edge is the trigger.
REQ-007 abort  in  1  level; when high, the running job is cancelled.
REQ-008 pixel_valid  in  1  one pixel produced by the datapath this cycle.
REQ-009 dp_reset  out  1  reset to the read/write datapath.
REQ-010 read_kernel  out  1  kernel load enable to the read path.
REQ-011 read_image  out  1  image stream enable to the read path.
REQ-012 busy  out  1  job in progress.
REQ-013 done  out  1  last job completed; sticky.
REQ-014 error  out  1  last job aborted or timed out; sticky.
REQ-015 pixel_count  out  16  pixels accepted in the current or last job.
REQ-016 status  out  32  {error, done, busy, 5'b0, state[7:0], pixel_count[15:0]} for the GPIO readback.

Function
REQ-017 States: IDLE, CLEAR, LOAD_K, STREAM, DRAIN, FINISH, FAULT.
REQ-018 IDLE: a start rising edge (start high, previous sample low) -> CLEAR; clear done, error and pixel_count.
REQ-019 CLEAR: dp_reset high for exactly 2 cycles, then -> LOAD_K.
REQ-020 LOAD_K: read_kernel high for exactly KERNEL_WAIT cycles, then -> STREAM.
REQ-021 STREAM: read_image high; each pixel_valid cycle increments pixel_count; the cycle pixel_count reaches NUM_PIXELS -> DRAIN.
REQ-022 STREAM: pixel_valid arriving in the same cycle as the transition into DRAIN is counted; pixel_valid outside STREAM is ignored and never counted.
REQ-023 pixel_count saturates at NUM_PIXELS and never wraps.
REQ-024 DRAIN: read_image low, wait DRAIN_CYCLES cycles (0 means one cycle), then -> FINISH.
REQ-025 FINISH: set done, drop busy, -> IDLE next cycle.
REQ-026 busy is high in CLEAR, LOAD_K, STREAM and DRAIN; low otherwise.
REQ-027 abort high in CLEAR, LOAD_K, STREAM or DRAIN -> FAULT next cycle; read_kernel and read_image low from that cycle.
REQ-028 FAULT: set error, dp_reset high for 1 cycle, -> IDLE; pixel_count holds its value.
REQ-029 abort takes priority over every other transition in the same cycle; abort in IDLE has no effect.
REQ-030 A start edge while busy is ignored.
REQ-031 A start held high across IDLE re-entry does not retrigger a job; a fresh rising edge is required.
REQ-032 read_kernel and read_image are never high in the same cycle.

Reset
REQ-033 While reset is high: state IDLE; dp_reset 1; read_kernel, read_image, busy, done and error 0; pixel_count 0; the start edge history register 0.
REQ-034 Reset asserted mid-job abandons the job and does not set error.

Configuration
REQ-035 With SEQ_TIMEOUT_EN defined: a 24-bit watchdog counts cycles in STREAM without pixel_valid, clears on each pixel_valid, and on reaching parameter TIMEOUT (default 2^20) moves the FSM to FAULT.
REQ-036 Without SEQ_TIMEOUT_EN: no watchdog logic exists and STREAM waits indefinitely.

Structure
REQ-037 Package conv_seq_pkg holds the state enum (8-bit encoding exported via status) and the status bit-position constants.
REQ-038 The watchdog is a sub-module, seq_watchdog, instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-039 Reset, then a start edge with NUM_PIXELS=4, KERNEL_WAIT=3, DRAIN_CYCLES=2 and 4 pixel_valid pulses: dp_reset 2 cycles, read_kernel 3 cycles, then read_image; done=1, pixel_count=4, busy low, status[31:29]=3'b010.
REQ-040 abort asserted during STREAM after 2 pixels: FAULT, error=1, pixel_count=2, read_image low on the next edge, one dp_reset pulse.
REQ-041 start held high through job completion: exactly one job runs; toggling start low then high starts a second job with done cleared.
REQ-042 pixel_valid in IDLE and in LOAD_K: pixel_count stays 0; pixel_valid in the final STREAM cycle is counted and the FSM enters DRAIN.
REQ-043 Reset pulsed mid-STREAM: all outputs return to reset values asynchronously and error stays 0.
REQ-044 With SEQ_TIMEOUT_EN and TIMEOUT=8, no pixels during STREAM: FAULT entered after 8 idle cycles and error=1.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared definitions for the convolution job sequencer.
//   - seq_state_e : FSM state enum; its 8-bit code is exported through the
//                   GPIO status word, so the encoding is part of the software
//                   interface and must stay stable.
//   - STAT_*      : bit positions of the fields inside the 32-bit status word.
//   - CLEAR_CYCLES: length of the datapath reset pulse at job start.
//   - is_busy_state(): states in which a job is considered in progress.
package conv_seq_pkg;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'd0,
    ST_CLEAR  = 8'd1,
    ST_LOAD_K = 8'd2,
    ST_STREAM = 8'd3,
    ST_DRAIN  = 8'd4,
    ST_FINISH = 8'd5,
    ST_FAULT  = 8'd6
  } seq_state_e;

  localparam int STAT_ERROR_BIT = 31;
  localparam int STAT_DONE_BIT  = 30;
  localparam int STAT_BUSY_BIT  = 29;
  localparam int STAT_STATE_LSB = 16;
  localparam int STAT_COUNT_LSB = 0;

  localparam int CLEAR_CYCLES = 2;

  function automatic logic is_busy_state(input seq_state_e s);
    logic busy_v;
    case (s)
      ST_CLEAR, ST_LOAD_K, ST_STREAM, ST_DRAIN: busy_v = 1'b1;
      default:                                  busy_v = 1'b0;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: stall detector for the pixel stream (exists only when
// SEQ_TIMEOUT_EN is defined).
//   clk, reset : clock, asynchronous active-high reset
//   active     : sequencer is in its streaming state
//   kick       : a pixel arrived this cycle (restarts the idle run)
//   expired    : this cycle is the TIMEOUT-th consecutive idle streaming cycle
// The counter holds completed idle cycles, so expiry is flagged during the
// idle cycle that completes the run and the FSM can leave on the next edge.
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int TIMEOUT = 32'd1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam logic [23:0] LIMIT_LAST = 24'(TIMEOUT - 1);

  logic [23:0] idle_cnt_r;

  assign expired = active & ~kick & (idle_cnt_r == LIMIT_LAST);

  // Idle-run counter: cleared outside streaming or on a pixel, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_r <= 24'd0;
    end else if (!active || kick) begin
      idle_cnt_r <= 24'd0;
    end else if (idle_cnt_r != LIMIT_LAST) begin
      idle_cnt_r <= idle_cnt_r + 24'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

endmodule
`endif

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: runs one convolution job per rising edge of start:
// datapath reset, kernel load, image stream, write drain, then report.
//   clk          : single clock
//   reset        : asynchronous active-high reset
//   start        : job request level; rising edge triggers a job from idle
//   abort        : cancels a running job
//   pixel_valid  : datapath produced one pixel this cycle
//   dp_reset     : reset to the read/write datapath
//   read_kernel  : kernel load enable
//   read_image   : image stream enable
//   busy         : job in progress
//   done / error : sticky completion / failure flags of the last job
//   pixel_count  : pixels accepted in the current or last job
//   status       : {error, done, busy, 5'b0, state[7:0], pixel_count[15:0]}
// Optional feature: define SEQ_TIMEOUT_EN to add a stream stall watchdog
// (parameter TIMEOUT) that faults the job when no pixel arrives in time.
// All outputs are registered: the next state is decoded and the outputs for
// that state are loaded on the same edge that enters it.
module conv_job_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_PIXELS   = 256,
  parameter int KERNEL_WAIT  = 16,
  parameter int DRAIN_CYCLES = 4
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 32'd1048576
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        pixel_valid,
  output logic        dp_reset,
  output logic        read_kernel,
  output logic        read_image,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] pixel_count,
  output logic [31:0] status
);

  // A zero drain length still spends one cycle in DRAIN.
  localparam int          DRAIN_LEN  = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
  localparam logic [7:0]  CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0]  KWAIT_LAST = 8'(KERNEL_WAIT - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_LEN - 1);
  localparam logic [15:0] NPIX       = 16'(NUM_PIXELS);
  localparam logic [15:0] NPIX_LAST  = 16'(NUM_PIXELS - 1);

  seq_state_e  state_r;
  seq_state_e  state_n_s;
  logic [7:0]  phase_cnt_r;
  logic        start_prev_r;
  logic        dp_reset_r;
  logic        read_kernel_r;
  logic        read_image_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [15:0] pixel_count_r;
  logic        start_edge_s;
  logic        job_start_s;
  logic        count_inc_s;
  logic        timeout_s;
  logic        stream_s;
  logic [31:0] status_s;

  assign start_edge_s = start & ~start_prev_r;
  assign job_start_s  = (state_r == ST_IDLE) & start_edge_s;
  assign stream_s     = (state_r == ST_STREAM);
  // Pixels count only while streaming; saturation guards against wrap.
  assign count_inc_s  = stream_s & pixel_valid & (pixel_count_r != NPIX);

`ifdef SEQ_TIMEOUT_EN
  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (stream_s),
    .kick    (pixel_valid),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode; abort (and stall timeout) outrank every other exit.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_n_s = ST_CLEAR;
        else              state_n_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (abort)                           state_n_s = ST_FAULT;
        else if (phase_cnt_r == CLEAR_LAST)  state_n_s = ST_LOAD_K;
        else                                 state_n_s = ST_CLEAR;
      end
      ST_LOAD_K: begin
        if (abort)                           state_n_s = ST_FAULT;
        else if (phase_cnt_r == KWAIT_LAST)  state_n_s = ST_STREAM;
        else                                 state_n_s = ST_LOAD_K;
      end
      ST_STREAM: begin
        if (abort || timeout_s)                          state_n_s = ST_FAULT;
        else if (pixel_valid && pixel_count_r == NPIX_LAST) state_n_s = ST_DRAIN;
        else                                             state_n_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (abort)                           state_n_s = ST_FAULT;
        else if (phase_cnt_r == DRAIN_LAST)  state_n_s = ST_FINISH;
        else                                 state_n_s = ST_DRAIN;
      end
      ST_FINISH: state_n_s = ST_IDLE;
      ST_FAULT:  state_n_s = ST_IDLE;
      default:   state_n_s = ST_IDLE;
    endcase
  end

  // State, per-state cycle counter and start edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      phase_cnt_r  <= 8'd0;
      start_prev_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      start_prev_r <= start;
      if (state_n_s != state_r) phase_cnt_r <= 8'd0;
      else                      phase_cnt_r <= phase_cnt_r + 8'd1;
    end
  end

  // Control outputs registered as a decode of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_reset_r    <= 1'b1;
      read_kernel_r <= 1'b0;
      read_image_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      dp_reset_r    <= (state_n_s == ST_CLEAR) | (state_n_s == ST_FAULT);
      read_kernel_r <= (state_n_s == ST_LOAD_K);
      read_image_r  <= (state_n_s == ST_STREAM);
      busy_r        <= is_busy_state(state_n_s);
    end
  end

  // Sticky result flags and pixel counter; a new job clears all three.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      pixel_count_r <= 16'd0;
    end else if (job_start_s) begin
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      pixel_count_r <= 16'd0;
    end else begin
      if (state_n_s == ST_FINISH) done_r <= 1'b1;
      else                        done_r <= done_r;
      if (state_n_s == ST_FAULT)  error_r <= 1'b1;
      else                        error_r <= error_r;
      if (count_inc_s) pixel_count_r <= pixel_count_r + 16'd1;
      else             pixel_count_r <= pixel_count_r;
    end
  end

  // Status word assembled from registered fields for GPIO readback.
  always_comb begin
    status_s                          = 32'd0;
    status_s[STAT_ERROR_BIT]          = error_r;
    status_s[STAT_DONE_BIT]           = done_r;
    status_s[STAT_BUSY_BIT]           = busy_r;
    status_s[STAT_STATE_LSB +: 8]     = state_r;
    status_s[STAT_COUNT_LSB +: 16]    = pixel_count_r;
  end

  assign dp_reset    = dp_reset_r;
  assign read_kernel = read_kernel_r;
  assign read_image  = read_image_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign pixel_count = pixel_count_r;
  assign status      = status_s;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: randomized job traffic against a timeline model.
// Each job's expected behaviour is planned from its phase boundaries:
// CLEAR [0,2), LOAD [2,2+KW), STREAM until the NPIX-th streamed pixel,
// DRAIN for DL cycles, FINISH, IDLE; an abort (or stall timeout) in cycle a
// gives FAULT at a+1 and IDLE at a+2. A single compare process checks every
// output each cycle; literal checks pin the directed scenarios.
module tb_conv_job_sequencer;
  import conv_seq_pkg::*;

  localparam int NPIX = 4;
  localparam int KW   = 3;
  localparam int DC   = 2;
  localparam int DL   = (DC == 0) ? 1 : DC;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO   = 8;
`endif

  typedef enum {P_IDLE, P_CLEAR, P_LOAD, P_STREAM, P_DRAIN, P_FINISH, P_FAULT} ph_e;

  logic        clk, reset, start, abort, pixel_valid;
  logic        dp_reset, read_kernel, read_image, busy, done, error;
  logic [15:0] pixel_count;
  logic [31:0] status;

  logic        m_done, m_err;
  int          m_cnt;
  logic        exp_dp, exp_rk, exp_ri, exp_busy, exp_done, exp_err;
  logic [7:0]  exp_state;
  logic [15:0] exp_cnt;
  logic [31:0] exp_status;
  bit          chk_en;
  int          n_vec, n_err, dpc, rkc, ric;
  int          pct, ac;

  conv_job_sequencer #(
    .NUM_PIXELS   (NPIX),
    .KERNEL_WAIT  (KW),
    .DRAIN_CYCLES (DC)
`ifdef SEQ_TIMEOUT_EN
    ,
    .TIMEOUT      (TO)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pixel_valid (pixel_valid),
    .dp_reset    (dp_reset),
    .read_kernel (read_kernel),
    .read_image  (read_image),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .pixel_count (pixel_count),
    .status      (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic rnd(input int p);
    return (int'($urandom_range(32'd0, 32'd99)) < p);
  endfunction

  function automatic logic [7:0] code(input ph_e p);
    case (p)
      P_CLEAR:  return 8'(ST_CLEAR);
      P_LOAD:   return 8'(ST_LOAD_K);
      P_STREAM: return 8'(ST_STREAM);
      P_DRAIN:  return 8'(ST_DRAIN);
      P_FINISH: return 8'(ST_FINISH);
      P_FAULT:  return 8'(ST_FAULT);
      default:  return 8'(ST_IDLE);
    endcase
  endfunction

  // Snapshot the expected outputs for the current cycle.
  task automatic set_exp(input ph_e p);
    exp_dp     = (p == P_CLEAR) || (p == P_FAULT);
    exp_rk     = (p == P_LOAD);
    exp_ri     = (p == P_STREAM);
    exp_busy   = (p == P_CLEAR) || (p == P_LOAD) || (p == P_STREAM) || (p == P_DRAIN);
    exp_done   = m_done;
    exp_err    = m_err;
    exp_state  = code(p);
    exp_cnt    = 16'(m_cnt);
    exp_status = {m_err, m_done, exp_busy, 5'b00000, exp_state, exp_cnt};
  endtask

  // The one per-cycle compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dp_reset",    32'(dp_reset),    32'(exp_dp));
      check("read_kernel", 32'(read_kernel), 32'(exp_rk));
      check("read_image",  32'(read_image),  32'(exp_ri));
      check("busy",        32'(busy),        32'(exp_busy));
      check("done",        32'(done),        32'(exp_done));
      check("error",       32'(error),       32'(exp_err));
      check("pixel_count", 32'(pixel_count), 32'(exp_cnt));
      check("status",      status,           exp_status);
      check("rk_ri_excl",  32'(read_kernel & read_image), 32'd0);
      if (dp_reset)    dpc++;
      if (read_kernel) rkc++;
      if (read_image)  ric++;
    end
  end

  task automatic idle_cycles(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_exp(P_IDLE);
      pixel_valid = rnd(p);
      abort       = rnd(30);
    end
  endtask

  // One job. abort_cyc: job-relative abort cycle (-1 none);
  // abort_pix: abort once this many pixels are counted (-1 none).
  task automatic run_job(input int p, input int abort_cyc, input int abort_pix, input bit hold);
    int  cnt, e, a, c;
    ph_e ph;
    logic ab, pv;
    bit  ended;
`ifdef SEQ_TIMEOUT_EN
    int  idle_run;
    idle_run = 0;
`endif
    @(posedge clk); #1;
    set_exp(P_IDLE);
    start = 1'b1; abort = 1'b0; pixel_valid = rnd(p);
    cnt = 0; e = -1; a = -1; ended = 1'b0;
    for (c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (a >= 0 && c == a + 1)      ph = P_FAULT;
      else if (a >= 0 && c > a + 1)  ph = P_IDLE;
      else if (c < 2)                ph = P_CLEAR;
      else if (c < 2 + KW)           ph = P_LOAD;
      else if (e < 0)                ph = P_STREAM;
      else if (c <= e + DL)          ph = P_DRAIN;
      else if (c == e + DL + 1)      ph = P_FINISH;
      else                           ph = P_IDLE;
      if (c == 0) begin m_done = 1'b0; m_err = 1'b0; m_cnt = 0; end
      if (ph == P_FINISH) m_done = 1'b1;
      if (ph == P_FAULT)  m_err  = 1'b1;
      set_exp(ph);
      ab = (a < 0) && (ph == P_CLEAR || ph == P_LOAD || ph == P_STREAM || ph == P_DRAIN)
           && (c == abort_cyc || (ph == P_STREAM && abort_pix >= 0 && cnt == abort_pix));
      pv = ab ? 1'b0 : rnd(p);
      abort = ab; pixel_valid = pv;
      if (!hold) start = (ph == P_IDLE) ? 1'b0 : 1'($urandom_range(32'd0, 32'd1));
      if (ab) a = c;
      if (ph == P_STREAM && pv) begin
        cnt++;
        if (cnt == NPIX) e = c;
      end
`ifdef SEQ_TIMEOUT_EN
      if (ph == P_STREAM && !ab && a < 0) begin
        if (pv) idle_run = 0;
        else begin
          idle_run++;
          if (idle_run == TO && e < 0) a = c;
        end
      end
`endif
      m_cnt = cnt;
      if (ph == P_IDLE) begin ended = 1'b1; break; end
    end
    if (!ended) begin
      n_vec++; n_err++;
      $display("FAIL job_end: job did not return to idle within cycle budget at %0t", $time);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0; pixel_valid = 1'b0;
    chk_en = 1'b0; n_vec = 0; n_err = 0; dpc = 0; rkc = 0; ric = 0;
    m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    #12;
    check("rst_dp_reset", 32'(dp_reset),    32'd1);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_rk_ri",    32'({read_kernel, read_image}), 32'd0);
    check("rst_status",   status,           32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    set_exp(P_IDLE); chk_en = 1'b1;

    // pixel_valid in idle is ignored
    idle_cycles(3, 100);
    @(negedge clk); #1;
    check("idle_pix_ignored", 32'(pixel_count), 32'd0);

    // nominal job, pixel every cycle
    dpc = 0; rkc = 0; ric = 0;
    run_job(100, -1, -1, 1'b0);
    @(negedge clk); #1;
    check("j1_dp_cycles",  32'(dpc), 32'd2);
    check("j1_rk_cycles",  32'(rkc), 32'd3);
    check("j1_ri_cycles",  32'(ric), 32'd4);
    check("j1_done",       32'(done), 32'd1);
    check("j1_count",      32'(pixel_count), 32'd4);
    check("j1_status_top", 32'(status[31:29]), 32'd2);

    // abort after two pixels
    dpc = 0; ric = 0;
    run_job(100, -1, 2, 1'b0);
    @(negedge clk); #1;
    check("ab_error",     32'(error), 32'd1);
    check("ab_done",      32'(done),  32'd0);
    check("ab_count",     32'(pixel_count), 32'd2);
    check("ab_dp_cycles", 32'(dpc), 32'd3);
    check("ab_ri_cycles", 32'(ric), 32'd3);

    // start held high across completion: no retrigger, then a fresh job
    run_job(60, -1, -1, 1'b1);
    idle_cycles(6, 50);
    @(negedge clk); #1;
    check("hold_no_retrigger", 32'(status[23:16]), 32'(ST_IDLE));
    start = 1'b0;
    run_job(60, -1, -1, 1'b0);

    // asynchronous reset in the middle of streaming
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b1; pixel_valid = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    check("pre_rst_streaming", 32'(read_image), 32'd1);
    check("pre_rst_count",     32'(pixel_count), 32'd1);
    reset = 1'b1; #1;
    check("mid_rst_dp_reset", 32'(dp_reset), 32'd1);
    check("mid_rst_status",   status, 32'd0);
    check("mid_rst_ri",       32'(read_image), 32'd0);
    @(posedge clk); #2;
    check("mid_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; pixel_valid = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    @(posedge clk); #1;
    set_exp(P_IDLE); chk_en = 1'b1;

`ifdef SEQ_TIMEOUT_EN
    // no pixels at all: watchdog faults the job
    run_job(0, -1, -1, 1'b0);
    @(negedge clk); #1;
    check("to_error", 32'(error), 32'd1);
    check("to_count", 32'(pixel_count), 32'd0);
`endif

    // randomized jobs with occasional aborts in any busy phase
    for (int j = 0; j < 40; j++) begin
      pct = int'($urandom_range(32'd20, 32'd100));
      if ($urandom_range(32'd0, 32'd2) == 32'd0)
        ac = int'($urandom_range(32'd0, 32'(2 + KW + NPIX + DL + 4)));
      else
        ac = -1;
      run_job(pct, ac, -1, 1'b0);
      idle_cycles(int'($urandom_range(32'd0, 32'd3)), 50);
    end

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
